// File: rtl/btn_cond_pkg.sv
// Shared constants for the five-button conditioner: button indices, direction codes
// and the default debounce period.
package btn_cond_pkg;

  // Bit positions of each button in btn_lvl / btn_press.
  localparam int unsigned BTN_U   = 0;
  localparam int unsigned BTN_D   = 1;
  localparam int unsigned BTN_L   = 2;
  localparam int unsigned BTN_R   = 3;
  localparam int unsigned BTN_C   = 4;
  localparam int unsigned NUM_BTN = 5;

  // One-hot direction codes presented on dir_req.
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  // 10 ms at 100 MHz.
  localparam int unsigned DB_LIMIT_DEFAULT = 1_000_000;

  // Map simultaneous direction pulses to one code, up > down > left > right.
  function automatic logic [3:0] dir_select(input logic [3:0] dir_press);
    logic [3:0] dir;
    dir = DIR_NONE;
    if (dir_press[BTN_U])      dir = DIR_UP;
    else if (dir_press[BTN_D]) dir = DIR_DOWN;
    else if (dir_press[BTN_L]) dir = DIR_LEFT;
    else if (dir_press[BTN_R]) dir = DIR_RIGHT;
    return dir;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button channel: 2-flop synchroniser, stability counter, debounced level and
// one-cycle rising-edge pulse.
module btn_debounce import btn_cond_pkg::*; #(
  parameter int unsigned DB_LIMIT = DB_LIMIT_DEFAULT,
  parameter int unsigned CNT_W    = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic lvl_o,
  output logic press_o
);

  // Last count before the stable value is allowed to change.
  localparam logic [CNT_W-1:0] LimitM1 = CNT_W'(DB_LIMIT - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Count consecutive disagreeing cycles; adopt the new value once the run is long enough.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LimitM1) begin
        stable_d = sync2_q;
        press_d  = sync2_q; // only a 0->1 change pulses
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debounce state, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign lvl_o   = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/btn_cond.sv
// Five push-button conditioner: debounces each button, latches the last requested
// direction and toggles a pause flag from the centre button.
module btn_cond import btn_cond_pkg::*; #(
  parameter int unsigned DB_LIMIT = DB_LIMIT_DEFAULT,
  parameter int unsigned CNT_W    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  output logic [4:0] btn_lvl,
  output logic [4:0] btn_press,
  output logic [3:0] dir_req,
  output logic       pause
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [3:0]         dir_sel;
  logic [3:0]         dir_req_q, dir_req_d;
  logic               pause_q, pause_d;

  assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce #(
      .DB_LIMIT (DB_LIMIT),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk_i     (clk),
      .rst_ni    (rst),
      .btn_raw_i (btn_raw[i]),
      .lvl_o     (btn_lvl[i]),
      .press_o   (btn_press[i])
    );
  end

  // Direction is only replaced by a new direction press; centre press toggles pause.
  always_comb begin
    dir_sel   = dir_select(btn_press[3:0]);
    dir_req_d = (dir_sel != DIR_NONE) ? dir_sel : dir_req_q;
    pause_d   = pause_q ^ btn_press[BTN_C];
  end

  // Direction latch and pause flag, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_req_q <= DIR_NONE;
      pause_q   <= 1'b0;
    end else begin
      dir_req_q <= dir_req_d;
      pause_q   <= pause_d;
    end
  end

  assign dir_req = dir_req_q;
  assign pause   = pause_q;

endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 SHALL have parameter DB_LIMIT, default 1_000_000, debounce stability period in clk cycles (10 ms at 100 MHz); legal range 2..2^20-1.
REQ-002 SHALL have parameter CNT_W, default 20, width of each debounce counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset: one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports btn_u, btn_d, btn_l, btn_r, btn_c, input, 1 each, raw asynchronous push-buttons, active-high.
REQ-006 SHALL have port btn_lvl, output, 5, debounced button levels; bit order is [4]=c, [3]=r, [2]=l, [1]=d, [0]=u.
REQ-007 SHALL have port btn_press, output, 5, one-cycle press pulses; same bit order as btn_lvl.
REQ-008 SHALL have port dir_req, output, 4, latched one-hot direction: [3]=up, [2]=down, [1]=left, [0]=right.
REQ-009 SHALL have port pause, output, 1, pause flag toggled by the centre button.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchroniser before any other use.
REQ-011 Per channel: the counter SHALL increment each cycle that the synchronised value differs from the stable value, and clear to 0 on any cycle they are equal.
REQ-012 When a mismatch persists and the counter equals DB_LIMIT-1, the stable value SHALL take the synchronised value and the counter SHALL clear, in the same cycle.
REQ-013 Latency: a raw change held steady SHALL appear on btn_lvl at exactly the (2+DB_LIMIT)th rising edge after the first edge that samples it.
REQ-014 A glitch shorter than DB_LIMIT cycles at synchroniser output SHALL leave btn_lvl unchanged and restart the count.
REQ-015 Releases SHALL be debounced identically to presses.
REQ-016 btn_press[i] SHALL be registered and high for exactly the one cycle in which btn_lvl[i] first reads 1 after reading 0.
REQ-017 Releases SHALL NOT produce a btn_press pulse.
REQ-018 Holding a button SHALL produce no further pulses (no auto-repeat).
REQ-019 On a direction press pulse, dir_req SHALL load that one-hot code on the edge after the pulse (1-cycle latency).
REQ-020 dir_req SHALL hold its value until the next direction press; it is never cleared by release.
REQ-021 When pulses for several directions occur in the same cycle, priority SHALL be up > down > left > right.
REQ-022 dir_req SHALL always be 0000 or exactly one-hot.
REQ-023 A btn_press[4] pulse SHALL toggle pause on the following edge.
REQ-024 A centre pulse SHALL NOT affect dir_req, and a direction pulse SHALL NOT affect pause.
REQ-025 Counters SHALL saturate logic-free: the clear in REQ-012 guarantees no wrap, and DB_LIMIT > 2^CNT_W-1 is illegal.

Reset
REQ-026 While rst=0 at a clock edge, the following SHALL be 0: all synchroniser flops, stable values, counters, btn_lvl, btn_press, dir_req, pause.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count.
REQ-028 After reset release, a button held throughout reset SHALL be reported as a fresh press, at latency per REQ-013 counted from the first edge with rst=1.

Structure
REQ-029 A shared package SHALL hold:
- button index constants BTN_U=0, BTN_D=1, BTN_L=2, BTN_R=3, BTN_C=4;
- direction one-hot constants DIR_UP=4'b1000, DIR_DOWN=4'b0100, DIR_LEFT=4'b0010, DIR_RIGHT=4'b0001, DIR_NONE=4'b0000;
- default DB_LIMIT.
REQ-030 Single-channel logic (synchroniser, counter, stable value, press pulse) SHALL be sub-module btn_debounce, instantiated 5 times.
REQ-031 The direction latch and pause toggle SHALL sit in btn_cond.

Verification (DB_LIMIT=4)
REQ-032 Scenario: clean press, btn_u rises before edge 1 and holds -> btn_lvl[0]=1 at edge 6; btn_press[0] high at edge 6 only; dir_req=1000 at edge 7.
REQ-033 Scenario: bounce, btn_l held high for 3 cycles, low for 1, then high -> btn_lvl[2] stays 0 through the glitch; rises 6 edges after the final rise is sampled; exactly one pulse.
REQ-034 Scenario: btn_d and btn_r rise in the same cycle -> both pulses coincide; dir_req=0100.
REQ-035 Scenario: btn_c pressed, released, pressed -> pause goes 0->1->0; dir_req unchanged; no pulse on release.
REQ-036 Scenario: rst=0 asserted 2 cycles into a btn_r debounce, held 3 cycles, btn_r kept high -> all outputs 0 during reset; btn_lvl[3] rises at the 6th edge after release.
REQ-037 Scenario: btn_u held for 50 cycles -> exactly one btn_press[0] pulse; dir_req stays 1000 after release.
